// File: rtl/inst_package.sv
// Shared sub-core definitions: core count, argument data type and the
// dispatcher's join state machine encoding.
package inst_package;

    localparam int SUBCORE_NUM = 8;
    localparam int DATA_W      = 32;
    localparam int PC_W        = 32;

    typedef logic [DATA_W-1:0] data_in;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JOIN = 2'd1,
        DONE = 2'd2
    } dispatch_state_t;

endpackage

// File: rtl/subcore_dispatcher_if.sv
// Bundle between the main core, the dispatcher and the sub cores.
//
// Fork handshake: a fork transfers on a rising edge where fork_valid and
// fork_ready are both 1 and join_req is 0. fork_ready depends on registered
// state only. The main core holds fork_valid and its payload until accepted.
// fork_id is valid in the accept cycle.
interface subcore_dispatcher_if #(
    parameter int N = inst_package::SUBCORE_NUM
);
    import inst_package::*;

    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    // main core side
    logic                   fork_valid;
    logic                   fork_ready;
    logic [PC_W-1:0]        fork_pc;
    data_in                 fork_u;
    data_in                 fork_l;
    logic [ID_W-1:0]        fork_id;
    logic                   join_req;
    logic                   join_done;

    // sub core side
    logic [N-1:0]           exec_requested;
    logic [N-1:0][PC_W-1:0] requested_pc;
    data_in [N-1:0]         u_n_in;
    data_in [N-1:0]         l_n_in;
    logic [N-1:0]           subcore_ended;

    // status and debug
    logic [N-1:0]           busy;
    logic [CNT_W-1:0]       active_count;
    logic                   spurious_end;
    dispatch_state_t        state;

    modport slave (
        input  fork_valid, fork_pc, fork_u, fork_l, join_req, subcore_ended,
        output fork_ready, fork_id, join_done, exec_requested, requested_pc,
               u_n_in, l_n_in, busy, active_count, spurious_end, state
    );

    modport master (
        output fork_valid, fork_pc, fork_u, fork_l, join_req, subcore_ended,
        input  fork_ready, fork_id, join_done, exec_requested, requested_pc,
               u_n_in, l_n_in, busy, active_count, spurious_end, state
    );

endinterface

// File: rtl/prio_enc_free.sv
// Lowest-zero finder: index of the lowest clear bit of busy, plus a flag
// telling whether any bit was clear at all.
module prio_enc_free #(
    parameter int N    = inst_package::SUBCORE_NUM,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    busy,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx   = ID_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/subcore_dispatcher.sv
// Dispatches fork requests from the main core to the lowest free sub core,
// tracks per-core occupancy and implements the join barrier.
module subcore_dispatcher #(
    parameter int SUBCORE_NUM = inst_package::SUBCORE_NUM
) (
    input  logic                 clk,
    input  logic                 rst,
    subcore_dispatcher_if.slave  bus
);
    import inst_package::*;

    localparam int N     = SUBCORE_NUM;
    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);

    dispatch_state_t        state_q;
    logic                   join_done_q;
    logic [N-1:0]           busy_q;
    logic [N-1:0]           exec_q;
    logic [CNT_W-1:0]       count_q;
    logic                   spurious_q;
    logic [N-1:0][PC_W-1:0] pc_q;
    data_in [N-1:0]         u_q;
    data_in [N-1:0]         l_q;

    logic [ID_W-1:0]        free_idx;
    logic                   free_found;
    logic                   ready;
    logic                   accept;
    logic [N-1:0]           set_mask;
    logic [N-1:0]           clear_mask;
    logic                   spurious_hit;
    logic [N-1:0]           busy_next;
    logic [CNT_W-1:0]       count_next;

    prio_enc_free #(.N(N), .ID_W(ID_W)) u_prio_enc_free (
        .busy  (busy_q),
        .idx   (free_idx),
        .found (free_found)
    );

    // Accept decision and occupancy update; a core freed this edge only
    // becomes visible to the encoder through busy_q one cycle later.
    always_comb begin
        ready        = (state_q == IDLE) && !(&busy_q);
        accept       = bus.fork_valid && ready && free_found && !bus.join_req;
        set_mask     = '0;
        if (accept) begin
            set_mask[free_idx] = 1'b1;
        end
        clear_mask   = bus.subcore_ended & busy_q;
        spurious_hit = |(bus.subcore_ended & ~busy_q);
        busy_next    = (busy_q & ~clear_mask) | set_mask;
    end

    // Population count of the next occupancy so active_count tracks busy.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < N; i++) begin
            count_next = count_next + CNT_W'(busy_next[i]);
        end
    end

    // Occupancy, launch pulses and per-core launch arguments.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            exec_q     <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
            pc_q       <= '0;
            u_q        <= '0;
            l_q        <= '0;
        end else begin
            busy_q  <= busy_next;
            exec_q  <= set_mask;
            count_q <= count_next;
            if (spurious_hit) begin
                spurious_q <= 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (set_mask[i]) begin
                    pc_q[i] <= bus.fork_pc;
                    u_q[i]  <= bus.fork_u;
                    l_q[i]  <= bus.fork_l;
                end
            end
        end
    end

    // Join barrier FSM; join_done is registered and high only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            join_done_q <= 1'b0;
        end else begin
            join_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.join_req) begin
                        if (busy_q == '0) begin
                            state_q     <= DONE;
                            join_done_q <= 1'b1;
                        end else begin
                            state_q <= JOIN;
                        end
                    end
                end
                JOIN: begin
                    if (busy_q == '0) begin
                        state_q     <= DONE;
                        join_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.fork_ready     = ready;
    assign bus.fork_id        = free_idx;
    assign bus.join_done      = join_done_q;
    assign bus.exec_requested = exec_q;
    assign bus.requested_pc   = pc_q;
    assign bus.u_n_in         = u_q;
    assign bus.l_n_in         = l_q;
    assign bus.busy           = busy_q;
    assign bus.active_count   = count_q;
    assign bus.spurious_end   = spurious_q;
    assign bus.state          = state_q;

endmodule

// File: doc/subcore_dispatcher.md
SUBCORE_DISPATCHER -- requirements
Module: subcore_dispatcher

Interface
REQ-001 SHALL have parameter SUBCORE_NUM, default 8, the number of attached sub cores.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port fork_valid, input, 1, main core requests a sub core launch.
REQ-005 SHALL have port fork_ready, output, 1, dispatcher can accept a fork this cycle.
REQ-006 SHALL have port fork_pc, input, 32, start PC for the launched sub core.
REQ-007 SHALL have ports fork_u and fork_l, input, data_in each, upper and lower argument data for the launch.
REQ-008 SHALL have port fork_id, output, clog2(SUBCORE_NUM), index chosen for the accepted fork; valid in the accept cycle.
REQ-009 SHALL have port join_req, input, 1, a single-cycle pulse; main core waits for all sub cores to finish.
REQ-010 SHALL have port join_done, output, 1, a single-cycle pulse when the join completes.
REQ-011 SHALL have port exec_requested, output, SUBCORE_NUM x 1, per-core start pulse.
REQ-012 SHALL have port requested_pc, output, SUBCORE_NUM x 32, per-core start PC.
REQ-013 SHALL have ports u_n_in and l_n_in, output, SUBCORE_NUM x data_in each, per-core argument data.
REQ-014 SHALL have port subcore_ended, input, SUBCORE_NUM x 1, per-core single-cycle completion pulse.
REQ-015 SHALL have port busy, output, SUBCORE_NUM, per-core occupancy bitmap.
REQ-016 SHALL have port active_count, output, clog2(SUBCORE_NUM+1), number of set busy bits.
REQ-017 SHALL have port spurious_end, output, 1, a sticky error flag.

Function
REQ-018 SHALL drive fork_ready = (state==IDLE) && (busy != all-ones), combinationally from registered state only.
REQ-019 SHALL accept a fork when fork_valid && fork_ready, and SHALL select the lowest-index core i with busy[i]==0.
REQ-020 On accept, the next cycle SHALL set busy[i], pulse exec_requested[i] for exactly one cycle, and load requested_pc[i], u_n_in[i] and l_n_in[i].
REQ-021 SHALL hold requested_pc[i], u_n_in[i] and l_n_in[i] stable until the next dispatch to core i.
REQ-022 A subcore_ended[i] pulse while busy[i]==1 SHALL clear busy[i] on the next edge.
REQ-023 A core freed at edge t SHALL be selectable no earlier than the cycle after t, so there is no same-cycle reuse.
REQ-024 A subcore_ended[i] pulse while busy[i]==0 SHALL be ignored for busy and SHALL set spurious_end, which stays set until reset.
REQ-025 Multiple simultaneous subcore_ended pulses SHALL all be honoured in the same edge.
REQ-026 active_count SHALL be registered and always equal popcount(busy); it is updated in the same edge as busy.
REQ-027 FSM states SHALL be IDLE, JOIN and DONE.
REQ-028 In IDLE, join_req with busy==0 SHALL go to DONE; join_req with busy!=0 SHALL go to JOIN.
REQ-029 In JOIN, the FSM SHALL move to DONE when busy==0.
REQ-030 DONE SHALL move to IDLE unconditionally, and join_done SHALL be 1 only in DONE.
REQ-031 join_req SHALL take priority over fork_valid in the same IDLE cycle, and that fork SHALL NOT be accepted.
REQ-032 join_req outside IDLE SHALL be ignored.
REQ-033 fork_valid SHALL be ignored when fork_ready==0, and the main core holds it.

Reset
REQ-034 rst SHALL clear busy, exec_requested, active_count, spurious_end and join_done, and SHALL set state to IDLE.
REQ-035 rst SHALL zero requested_pc, u_n_in and l_n_in.
REQ-036 rst mid-operation SHALL abandon the join and outstanding cores without emitting join_done; later subcore_ended pulses from those cores set spurious_end.

Structure
REQ-037 SUBCORE_NUM and data_in SHALL come from the shared inst_package, and the state enum SHALL be added there.
REQ-038 The free-core selection SHALL be one sub-module, prio_enc_free, combinational: a lowest-zero finder giving index plus a found flag.

Verification
REQ-039 Scenario: after reset, fork pc=0x100 -> exec_requested[0] pulses 1 cycle later, requested_pc[0]=0x100, busy=0x01, active_count=1.
REQ-040 Scenario: 8 back-to-back forks -> cores 0..7 are assigned in order, fork_ready=0 after the 8th, and a 9th fork_valid is held without acceptance.
REQ-041 Scenario: with all busy, subcore_ended[3] pulses -> busy=0xF7 next cycle, and the next fork goes to core 3 one cycle later, not earlier.
REQ-042 Scenario: busy=0x05, join_req -> state JOIN, fork_ready=0; ended[0] then ended[2] -> join_done exactly one cycle after busy reaches 0.
REQ-043 Scenario: join_req with busy=0 -> join_done the next cycle; join_req and fork_valid together -> no dispatch.
REQ-044 Scenario: subcore_ended[5] with busy[5]=0 -> spurious_end=1, busy unchanged; rst during JOIN -> IDLE, no join_done.
